// File: rtl/ram_sync_clr.sv
// ram_sync_clr: synchronous single-port RAM, 1-cycle read latency with a
// read-valid strobe, and a built-in engine that sweeps every word to CLR_VAL.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   direccion          word address for read or write
//   Dato_E, EN         write data and write enable
//   RD                 read request, result on dato_s one cycle later
//   clr                one-cycle pulse that starts a clear sweep
//   dato_s, dato_v     registered read data and its 1-cycle valid strobe
//   ocupado            high while the clear sweep runs; accesses dropped
module ram_sync_clr #(
   parameter int                DATA_W  = 8,
   parameter int                ADDR_W  = 8,
   parameter int                DEPTH   = 1 << ADDR_W,
   parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] direccion,
   input  logic [DATA_W-1:0] Dato_E,
   input  logic              EN,
   input  logic              RD,
   input  logic              clr,
   output logic [DATA_W-1:0] dato_s,
   output logic              dato_v,
   output logic              ocupado
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   typedef enum logic {
      CLEAR,
      IDLE
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] ptr, ptr_nxt;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              in_rng;
   logic [IDX_W-1:0]  idx;
   logic              wr_en;
   logic [IDX_W-1:0]  wr_idx;
   logic [DATA_W-1:0] wr_data;
   logic              rd_go;

   // Addresses at or above DEPTH exist only when DEPTH < 2**ADDR_W.
   assign in_rng = (32'(direccion) < 32'(DEPTH));
   assign idx    = direccion[IDX_W-1:0];

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      wr_en     = 1'b0;
      wr_idx    = idx;
      wr_data   = Dato_E;
      rd_go     = 1'b0;
      unique case (state)
         CLEAR: begin
            wr_en   = 1'b1;
            wr_idx  = ptr[IDX_W-1:0];
            wr_data = CLR_VAL;
            if (ptr == LAST) begin
               state_nxt = IDLE;
            end else begin
               ptr_nxt = ptr + 1'b1;
            end
         end
         IDLE: begin
            if (clr) begin
               // The clear request wins; any access this cycle is dropped.
               state_nxt = CLEAR;
               ptr_nxt   = '0;
            end else begin
               wr_en = EN && in_rng;
               rd_go = RD;
            end
         end
         default: state_nxt = CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= CLEAR;
         ptr    <= '0;
         dato_s <= '0;
         dato_v <= 1'b0;
      end else begin
         state  <= state_nxt;
         ptr    <= ptr_nxt;
         dato_v <= rd_go;
         if (rd_go) begin
            dato_s <= in_rng ? mem[idx] : CLR_VAL;
         end
      end
   end

   // Storage has no reset; the sweep after reset rewrites every word.
   // The read above sees the old word, giving read-before-write.
   always_ff @(posedge clk) begin
      if (!rst && wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   assign ocupado = (state == CLEAR);

endmodule

// File: tb/tb_ram_sync_clr.sv
// tb_ram_sync_clr: drives a full-depth RAM and a 200-word RAM, checking
// every cycle against a behavioural memory model plus directed values.
module tb_ram_sync_clr;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [7:0] CV1 = 8'hA5;

   logic       rst_i [2];
   logic [7:0] dir_i [2];
   logic [7:0] dat_i [2];
   logic       en_i  [2];
   logic       rd_i  [2];
   logic       clr_i [2];
   logic [7:0] ds    [2];
   logic       dv    [2];
   logic       oc    [2];

   ram_sync_clr u0 (
      .clk(clk), .rst(rst_i[0]), .direccion(dir_i[0]),
      .Dato_E(dat_i[0]), .EN(en_i[0]), .RD(rd_i[0]), .clr(clr_i[0]),
      .dato_s(ds[0]), .dato_v(dv[0]), .ocupado(oc[0])
   );

   ram_sync_clr #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .CLR_VAL(CV1)) u1 (
      .clk(clk), .rst(rst_i[1]), .direccion(dir_i[1]),
      .Dato_E(dat_i[1]), .EN(en_i[1]), .RD(rd_i[1]), .clr(clr_i[1]),
      .dato_s(ds[1]), .dato_v(dv[1]), .ocupado(oc[1])
   );

   // Reference model: plain arrays and a count of sweep writes done.
   int         depth [2] = '{256, 200};
   logic [7:0] cval  [2] = '{8'h00, CV1};
   logic [7:0] m     [2][256];
   bit         busy  [2];
   int         swept [2];
   logic [7:0] es    [2];
   logic       ev    [2];

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(int k);
      if (rst_i[k]) begin
         busy[k] = 1; swept[k] = 0; es[k] = 0; ev[k] = 0;
      end else if (busy[k]) begin
         m[k][swept[k]] = cval[k];
         swept[k]++;
         if (swept[k] == depth[k]) busy[k] = 0;
         ev[k] = 0;
      end else if (clr_i[k]) begin
         busy[k] = 1; swept[k] = 0; ev[k] = 0;
      end else begin
         ev[k] = rd_i[k];
         if (rd_i[k])
            es[k] = (int'(dir_i[k]) < depth[k]) ? m[k][dir_i[k]] : cval[k];
         if (en_i[k] && int'(dir_i[k]) < depth[k])
            m[k][dir_i[k]] = dat_i[k];
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      for (int k = 0; k < 2; k++) model_edge(k);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("d%0d.ocupado", k), 32'(oc[k]), 32'(busy[k]));
         chk($sformatf("d%0d.dato_v", k), 32'(dv[k]), 32'(ev[k]));
         chk($sformatf("d%0d.dato_s", k), 32'(ds[k]), 32'(es[k]));
      end
   endtask

   task automatic idle(int k);
      en_i[k] = 0; rd_i[k] = 0; clr_i[k] = 0;
   endtask

   // Counts post-edge samples with ocupado high, starting with the
   // sample already taken before the call.
   task automatic busy_len(int k, output int n);
      n = 1;
      while (oc[k] && n < 1000) begin
         cyc();
         if (oc[k]) n++;
      end
   endtask

   task automatic wr(int k, int a, int d);
      en_i[k] = 1; rd_i[k] = 0; dir_i[k] = 8'(a); dat_i[k] = 8'(d);
      cyc();
      en_i[k] = 0;
   endtask

   task automatic rd(int k, int a);
      rd_i[k] = 1; en_i[k] = 0; dir_i[k] = 8'(a);
      cyc();
      rd_i[k] = 0;
   endtask

   int n;
   int ra [5] = '{3, 6, 8, 9, 10};
   int rv [5] = '{111, 77, 55, 22, 200};
   int za [5] = '{0, 1, 2, 5, 10};

   initial begin
      for (int k = 0; k < 2; k++) begin
         idle(k); rst_i[k] = 1; dir_i[k] = 0; dat_i[k] = 0;
      end
      // Test 1: reset full-depth RAM; the small one stays in reset.
      cyc(); cyc();
      chk("rst.ocupado", 32'(oc[0]), 32'd1);
      chk("rst.dato_v", 32'(dv[0]), 32'd0);
      chk("rst.dato_s", 32'(ds[0]), 32'd0);
      rst_i[0] = 0;
      busy_len(0, n);
      chk("sweep256", n, 256);
      for (int i = 0; i < 5; i++) begin
         rd(0, za[i]);
         chk("zero.v", 32'(dv[0]), 32'd1);
         chk("zero.s", 32'(ds[0]), 32'd0);
      end
      cyc();
      chk("rd_gap.v", 32'(dv[0]), 32'd0);

      // Test 2: writes then back-to-back reads.
      for (int i = 0; i < 5; i++) wr(0, ra[i], rv[i]);
      for (int i = 0; i < 5; i++) begin
         rd_i[0] = 1; dir_i[0] = 8'(ra[i]);
         cyc();
         chk("b2b.v", 32'(dv[0]), 32'd1);
         chk("b2b.s", 32'(ds[0]), 32'(rv[i]));
      end
      rd_i[0] = 0;

      // Test 3: read-before-write on the same address.
      wr(0, 4, 9);
      en_i[0] = 1; rd_i[0] = 1; dir_i[0] = 4; dat_i[0] = 33;
      cyc();
      en_i[0] = 0; rd_i[0] = 0;
      chk("rbw.old", 32'(ds[0]), 32'd9);
      rd(0, 4);
      chk("rbw.new", 32'(ds[0]), 32'd33);

      // Test 4: clr with a colliding write.
      clr_i[0] = 1; en_i[0] = 1; dir_i[0] = 3; dat_i[0] = 99;
      cyc();
      idle(0);
      busy_len(0, n);
      chk("clr.len", n, 256);
      rd(0, 3);
      chk("clr.rd3", 32'(ds[0]), 32'd0);

      // Random traffic on the full-depth RAM.
      for (int i = 0; i < 400; i++) begin
         en_i[0] = 1'($urandom);
         rd_i[0] = 1'($urandom);
         dir_i[0] = 8'($urandom);
         dat_i[0] = 8'($urandom);
         cyc();
      end
      idle(0);

      // Test 5: reset at sweep cycle 100.
      clr_i[0] = 1;
      cyc();
      clr_i[0] = 0;
      repeat (100) cyc();
      rst_i[0] = 1;
      cyc();
      rst_i[0] = 0;
      busy_len(0, n);
      chk("rst_mid.len", n, 256);

      // Test 6: 200-word RAM with out-of-range accesses.
      cyc();
      rst_i[1] = 0;
      busy_len(1, n);
      chk("sweep200", n, 200);
      wr(1, 250, 8'h5A);
      rd(1, 250);
      chk("oor.v", 32'(dv[1]), 32'd1);
      chk("oor.s", 32'(ds[1]), 32'(CV1));
      rd(1, 199);
      chk("last.s", 32'(ds[1]), 32'(CV1));
      wr(1, 199, 8'h3C);
      rd(1, 199);
      chk("last.w", 32'(ds[1]), 32'h3C);
      for (int i = 0; i < 400; i++) begin
         en_i[1] = 1'($urandom);
         rd_i[1] = 1'($urandom);
         dir_i[1] = 8'($urandom);
         dat_i[1] = 8'($urandom);
         cyc();
      end
      idle(1);
      cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
